button_event_classifier: RTL

//  Consumes the debounced level from the button debounce stage and classifies each press.

---
 rtl/button_event_classifier.sv | 125 ++++++++++++
 1 files changed

// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into press/release/click/long/repeat pulses.
// Optional auto-repeat is built only when AUTO_REPEAT_EN is defined.
module button_event_classifier #(
  parameter int LONG_COUNT   = 6000000,
  parameter int LONG_W       = 23,
  parameter int REPEAT_COUNT = 1200000,
  parameter int REPEAT_W     = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic click_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  typedef enum logic [1:0] {IDLE, PRESSED, LONG} state_t;

  // Reject terminal counts that cannot be reached or do not fit their counters.
  if (LONG_COUNT < 2 || REPEAT_COUNT < 2 ||
      LONG_COUNT >= (1 << LONG_W) || REPEAT_COUNT >= (1 << REPEAT_W)) begin : g_bad_params
    $error("button_event_classifier: invalid count/width parameters");
  end

  localparam logic [LONG_W-1:0] HOLD_LAST = LONG_W'(LONG_COUNT);

  state_t            state;
  logic              btn_q;
  logic [LONG_W-1:0] hold_cnt;
  logic              rise;
  logic              fall;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

`ifdef AUTO_REPEAT_EN
  localparam logic [REPEAT_W-1:0] REP_LAST = REPEAT_W'(REPEAT_COUNT - 1);
  logic [REPEAT_W-1:0] rep_cnt;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      btn_q         <= 1'b0;
      hold_cnt      <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      held          <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt       <= '0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      btn_q         <= btn_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (rise) begin
            press_pulse <= 1'b1;
            hold_cnt    <= LONG_W'(1);
            held        <= 1'b1;
            state       <= PRESSED;
          end
        end
        PRESSED: begin
          // A fall on the terminal cycle takes priority: the press is still a click.
          if (fall) begin
            release_pulse <= 1'b1;
            click_pulse   <= 1'b1;
            hold_cnt      <= '0;
            held          <= 1'b0;
            state         <= IDLE;
          end else if (hold_cnt == HOLD_LAST) begin
            long_pulse <= 1'b1;
            hold_cnt   <= '0;
`ifdef AUTO_REPEAT_EN
            rep_cnt    <= '0;
`endif
            state      <= LONG;
          end else begin
            hold_cnt <= hold_cnt + LONG_W'(1);
          end
        end
        LONG: begin
          if (fall) begin
            release_pulse <= 1'b1;
            hold_cnt      <= '0;
            held          <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rep_cnt       <= '0;
`endif
            state         <= IDLE;
          end
`ifdef AUTO_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            repeat_pulse <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= rep_cnt + REPEAT_W'(1);
          end
`endif
        end
        default: begin
          hold_cnt <= '0;
          held     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
